systolic_array_collector: RTL and testbench
===========================================

# systolic_array_collector

Output-side collector for the 10×5 systolic array in the NICE CNN accelerator. Column results leave the array's bottom edge skewed in time, with column j arriving j cycles after column 0 for the same result row. This block captures each column's `en_down`/`data_down` stream into its own FIFO and re-aligns the columns into full COLS-wide result vectors. It presents those vectors to the NICE write-back path over a valid/ready handshake, counts vectors per tile, and flags overflow.

## Interface
- `L_WIDTH`, 32, result/accumulator width per column.
- `COLS`, 5, number of array columns.
- `DEPTH`, 8, entries per column FIFO; power of two, ≥ COLS.
- `CNT_W`, 16, width of the tile vector count.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `clr`  in  1  synchronous flush: empties FIFOs, clears counter and `overflow`, forces IDLE.
- `start`  in  1  pulse; latches `cfg_num` and begins a tile.
- `cfg_num`  in  CNT_W  number of result vectors in the tile.
- `en_down`  in  COLS  per-column valid from the array bottom.
- `data_down`  in  L_WIDTH × [COLS]  per-column result from the array bottom.
- `out_valid`  out  1  aligned vector available.
- `out_ready`  in  1  consumer accepts the vector.
- `out_data`  out  L_WIDTH × [COLS]  aligned vector; element j is column j.
- `tile_done`  out  1  one-cycle pulse at tile end.
- `overflow`  out  1  sticky; set when a column write is dropped.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- FSM states: IDLE, COLLECT, DONE.
- Transitions:
  - IDLE → COLLECT on `start`; `cfg_num` is latched and the vector count is set to 0.
  - COLLECT → DONE on the handshake that makes count == latched `cfg_num`.
  - `start` with `cfg_num` = 0: IDLE → DONE directly.
  - DONE → IDLE unconditionally after one cycle; `tile_done` = 1 only in DONE.
- Push: in COLLECT, `en_down[j]` writes `data_down[j]` into FIFO j.
  - Push to a full FIFO is dropped and sets `overflow`, unless a pop happens in the same cycle; a simultaneous push+pop on a full FIFO succeeds.
  - `en_down` in IDLE or DONE is dropped and sets `overflow`.
- Alignment: `out_valid` = all COLS FIFOs non-empty and state == COLLECT.
  - `out_data` = the FIFO heads, and is 0 when `out_valid` = 0.
- Pop: handshake (`out_valid` & `out_ready`) pops every FIFO by one entry and increments the count.
- Pointers: log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH, plus a per-FIFO occupancy counter (0..DEPTH).
- `clr` has priority over `start`, push and pop in the same cycle.
- `start` while not in IDLE is ignored.
- No arithmetic on the data path other than the optional ReLU (see Configuration).

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `tile_done` 0, `overflow` 0, `busy` 0; FIFOs empty; state IDLE.
- `rst` takes effect asynchronously: outputs go to their reset values without waiting for a clock edge.
- Push latency: an entry written at edge t is visible at the FIFO head after edge t; `out_valid` is combinational from the occupancy counters.
- Skewed row: with column j pushed at edge t0+j, `out_valid` rises after edge t0+COLS−1.
- Throughput: one vector per cycle while every FIFO holds data and `out_ready` = 1.
- Handshake: `out_data` is stable while `out_valid` & !`out_ready`; `out_valid` never drops without a pop, except on `clr`/`rst`.
- `tile_done` asserts in the cycle after the final handshake; `busy` falls one cycle later.

## Configuration
- Macro: `SYS_COLLECT_RELU_EN`.
- Defined: each `out_data` element is interpreted as signed L_WIDTH; negative values are output as 0 and non-negative values pass through. The ReLU is applied combinationally after the FIFO head; stored data is unmodified.
- Undefined: `out_data` equals the FIFO heads bit-for-bit.

## Test plan
- Skewed single vector: `start`, `cfg_num`=1, column j pushed at t0+j with value 100+j, `out_ready`=1 → one handshake with `out_data`={100,101,102,103,104}; `tile_done` pulses once the cycle after; `busy` falls the following cycle.
- Backpressure: `cfg_num`=4, push 4 skewed rows (values 10·r+j) with `out_ready`=0 → `out_valid`=1 with row 0 held stable; then `out_ready`=1 → 4 consecutive beats in order rows 0..3, then `tile_done`.
- Overflow: `out_ready`=0, push 9 values (1..9) into column 0 only → `overflow`=1 and stays 1; after filling the other columns, the drained column-0 sequence is 1..8; `clr` → `overflow`=0, all FIFOs empty.
- Full push+pop: all FIFOs full, `out_ready`=1, and a new skewed row whose pushes coincide with pops → no overflow; the pushed row is delivered after the 8 stored rows.
- ReLU: `data_down[2]`=32'hFFFF_FFF6 → `out_data[2]`=0 with `SYS_COLLECT_RELU_EN` defined, 32'hFFFF_FFF6 without; 32'h0000_0007 passes through in both builds.
- Reset mid-tile: assert `rst` in COLLECT with 3 entries per FIFO → `out_valid`=0 and `busy`=0 before the next edge; after release, a new tile with `cfg_num`=1 behaves as in the first scenario.

Source files
------------

// File: rtl/systolic_array_collector_if.sv
// Column streams from the array bottom edge in, aligned result vectors out over valid/ready.
interface systolic_array_collector_if #(
   parameter int L_WIDTH = 32,
   parameter int COLS    = 5
);
   logic [COLS-1:0]              en_down;
   logic [COLS-1:0][L_WIDTH-1:0] data_down;
   logic                         out_valid;
   logic                         out_ready;
   logic [COLS-1:0][L_WIDTH-1:0] out_data;

   modport master (
      output en_down, data_down, out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  en_down, data_down, out_ready,
      output out_valid, out_data
   );
endinterface

// File: rtl/systolic_array_collector.sv
// Re-aligns skewed systolic column outputs into COLS-wide vectors; optional ReLU via SYS_COLLECT_RELU_EN.
// Latency: a column entry is visible at its FIFO head one edge after the push; out_valid is combinational.
// Backpressure: out_ready low holds the head vector; pushes into a full FIFO are dropped and flagged.
module systolic_array_collector #(
   parameter int L_WIDTH = 32,
   parameter int COLS    = 5,
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 start,
   input  logic [CNT_W-1:0]     cfg_num,
   systolic_array_collector_if.slave bus,
   output logic                 tile_done,
   output logic                 overflow,
   output logic                 busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   num;

   logic [L_WIDTH-1:0] mem    [COLS][DEPTH];
   logic [AW-1:0]      wr_ptr [COLS];
   logic [AW-1:0]      rd_ptr [COLS];
   logic [AW:0]        occ    [COLS];

   logic [COLS-1:0]    nonempty;
   logic [COLS-1:0]    push;
   logic [COLS-1:0]    drop;
   logic               pop;

   always_comb begin
      nonempty = '0;
      for (int j = 0; j < COLS; j++) begin
         nonempty[j] = (occ[j] != '0);
      end
   end

   assign bus.out_valid = (state == COLLECT) && (&nonempty);
   assign pop           = bus.out_valid && bus.out_ready && !clr;

   // A full FIFO still accepts a push when the same cycle pops it.
   always_comb begin
      push = '0;
      drop = '0;
      for (int j = 0; j < COLS; j++) begin
         if (!clr && bus.en_down[j]) begin
            if (state == COLLECT && (occ[j] != FULL_OCC || pop)) begin
               push[j] = 1'b1;
            end else begin
               drop[j] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      bus.out_data = '0;
      if (bus.out_valid) begin
         for (int j = 0; j < COLS; j++) begin
`ifdef SYS_COLLECT_RELU_EN
            bus.out_data[j] = mem[j][rd_ptr[j]][L_WIDTH-1] ? '0 : mem[j][rd_ptr[j]];
`else
            bus.out_data[j] = mem[j][rd_ptr[j]];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < COLS; j++) begin
         if (push[j]) begin
            mem[j][wr_ptr[j]] <= bus.data_down[j];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < COLS; j++) begin
            wr_ptr[j] <= '0;
            rd_ptr[j] <= '0;
            occ[j]    <= '0;
         end
      end else if (clr) begin
         for (int j = 0; j < COLS; j++) begin
            wr_ptr[j] <= '0;
            rd_ptr[j] <= '0;
            occ[j]    <= '0;
         end
      end else begin
         for (int j = 0; j < COLS; j++) begin
            if (push[j]) wr_ptr[j] <= wr_ptr[j] + 1'b1;
            if (pop)     rd_ptr[j] <= rd_ptr[j] + 1'b1;
            if (push[j] && !pop) begin
               occ[j] <= occ[j] + 1'b1;
            end else if (!push[j] && pop) begin
               occ[j] <= occ[j] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (clr) begin
         overflow <= 1'b0;
      end else if (|drop) begin
         overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         num   <= '0;
      end else begin
         state <= state_nxt;
         if (clr) begin
            cnt <= '0;
         end else if (state == IDLE && start) begin
            cnt <= '0;
            num <= cfg_num;
         end else if (pop) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = (cfg_num == '0) ? DONE : COLLECT;
         end
         COLLECT: begin
            if (pop && (cnt + 1'b1) == num) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (clr) state_nxt = IDLE;
   end

   assign tile_done = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_systolic_array_collector.sv
// Directed and randomized stimulus checked against a queue-based model of the collector.
module tb_systolic_array_collector;
   localparam int L_WIDTH = 32;
   localparam int COLS    = 5;
   localparam int DEPTH   = 8;
   localparam int CNT_W   = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             clr;
   logic             start;
   logic [CNT_W-1:0] cfg_num;
   logic             tile_done;
   logic             overflow;
   logic             busy;

   systolic_array_collector_if #(.L_WIDTH(L_WIDTH), .COLS(COLS)) bus ();

   systolic_array_collector #(
      .L_WIDTH(L_WIDTH), .COLS(COLS), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .clr(clr), .start(start), .cfg_num(cfg_num),
      .bus(bus), .tile_done(tile_done), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int done_seen   = 0;

   // Reference model: one queue per column, tile state as plain integers.
   logic [L_WIDTH-1:0] mq [COLS][$];
   int                 m_state = 0;   // 0 idle, 1 collecting, 2 done
   int                 m_cnt   = 0;
   int                 m_num   = 0;
   bit                 m_ovf   = 0;
   logic [COLS-1:0][L_WIDTH-1:0] got [$];

   function automatic logic [31:0] exp_elem(input logic [31:0] v);
`ifdef SYS_COLLECT_RELU_EN
      return v[31] ? 32'd0 : v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < COLS; j++) mq[j].delete();
      m_state = 0; m_cnt = 0; m_num = 0; m_ovf = 0;
   endtask

   // Called just after a falling edge with inputs set: check outputs, advance model, step one clock.
   task automatic cycle();
      bit mv;
      bit hs;
      mv = (m_state == 1);
      for (int j = 0; j < COLS; j++) if (mq[j].size() == 0) mv = 0;
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, mv});
      for (int j = 0; j < COLS; j++)
         check($sformatf("out_data[%0d]", j), bus.out_data[j], mv ? exp_elem(mq[j][0]) : 32'd0);
      check("tile_done", {31'd0, tile_done}, {31'd0, (m_state == 2)});
      check("busy", {31'd0, busy}, {31'd0, (m_state != 0)});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      if (tile_done) done_seen++;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);

      if (clr) begin
         for (int j = 0; j < COLS; j++) mq[j].delete();
         m_ovf = 0; m_state = 0; m_cnt = 0;
      end else begin
         hs = mv && bus.out_ready;
         if (hs) for (int j = 0; j < COLS; j++) void'(mq[j].pop_front());
         for (int j = 0; j < COLS; j++) begin
            if (bus.en_down[j]) begin
               if (m_state == 1 && mq[j].size() < DEPTH) mq[j].push_back(bus.data_down[j]);
               else m_ovf = 1;
            end
         end
         case (m_state)
            0: if (start) begin
                  m_num = int'(cfg_num); m_cnt = 0;
                  m_state = (cfg_num == 0) ? 2 : 1;
               end
            1: if (hs) begin
                  m_cnt++;
                  if (m_cnt == m_num) m_state = 2;
               end
            default: m_state = 0;
         endcase
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic go(input int n);
      start = 1'b1; cfg_num = CNT_W'(n);
      cycle();
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.en_down = '0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Column j pushed j cycles after column 0, value base+j.
   task automatic skew_row(input logic [31:0] base);
      for (int k = 0; k < COLS; k++) begin
         bus.en_down = '0;
         bus.en_down[k] = 1'b1;
         bus.data_down[k] = base + 32'(k);
         cycle();
      end
      bus.en_down = '0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; start = 1'b0; cfg_num = '0;
      bus.en_down = '0; bus.data_down = '0; bus.out_ready = 1'b0;
      #1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_data0", bus.out_data[0], 32'd0);
      check("rst_tile_done", {31'd0, tile_done}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Skewed single vector
      got.delete(); done_seen = 0;
      bus.out_ready = 1'b1;
      go(1);
      skew_row(32'd100);
      idle(4);
      check("s1_beats", got.size(), 32'd1);
      if (got.size() > 0) for (int j = 0; j < COLS; j++) check("s1_data", got[0][j], 32'd100 + 32'(j));
      check("s1_done_pulses", done_seen, 32'd1);

      // Backpressure: 4 skewed rows held, then drained
      got.delete(); done_seen = 0;
      bus.out_ready = 1'b0;
      go(4);
      for (int c = 0; c < 4 + COLS - 1; c++) begin
         for (int j = 0; j < COLS; j++) begin
            bus.en_down[j] = (c - j >= 0) && (c - j < 4);
            bus.data_down[j] = 32'(10 * (c - j) + j);
         end
         cycle();
      end
      idle(3);
      check("s2_held_valid", {31'd0, bus.out_valid}, 32'd1);
      check("s2_held_col4", bus.out_data[4], 32'd4);
      bus.out_ready = 1'b1;
      idle(6);
      check("s2_beats", got.size(), 32'd4);
      for (int r = 0; r < 4; r++)
         if (got.size() > r) for (int j = 0; j < COLS; j++)
            check("s2_data", got[r][j], 32'(10 * r + j));
      check("s2_done_pulses", done_seen, 32'd1);

      // Overflow on column 0, then clr
      got.delete();
      bus.out_ready = 1'b0;
      go(8);
      for (int v = 1; v <= 9; v++) begin
         bus.en_down = 5'b00001; bus.data_down[0] = 32'(v);
         cycle();
      end
      for (int v = 0; v < 8; v++) begin
         bus.en_down = 5'b11110;
         for (int j = 1; j < COLS; j++) bus.data_down[j] = 32'(500 + v);
         cycle();
      end
      check("s3_overflow", {31'd0, overflow}, 32'd1);
      bus.out_ready = 1'b1;
      idle(10);
      check("s3_beats", got.size(), 32'd8);
      for (int r = 0; r < 8; r++) if (got.size() > r) check("s3_col0", got[r][0], 32'(r + 1));
      check("s3_overflow_sticky", {31'd0, overflow}, 32'd1);
      go(2);
      bus.en_down = 5'b00001; bus.data_down[0] = 32'd55;
      cycle(); cycle();
      bus.en_down = '0;
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      check("s3_clr_overflow", {31'd0, overflow}, 32'd0);
      check("s3_clr_busy", {31'd0, busy}, 32'd0);
      got.delete();
      go(1);
      skew_row(32'd200);
      idle(4);
      check("s3_flush_beats", got.size(), 32'd1);
      if (got.size() > 0) check("s3_flush_col0", got[0][0], 32'd200);

      // Full FIFOs with simultaneous push and pop
      got.delete();
      bus.out_ready = 1'b0;
      go(9);
      for (int r = 0; r < DEPTH; r++) begin
         bus.en_down = '1;
         for (int j = 0; j < COLS; j++) bus.data_down[j] = 32'(1000 + 10 * r + j);
         cycle();
      end
      bus.out_ready = 1'b1;
      skew_row(32'd77);
      idle(8);
      check("s4_overflow", {31'd0, overflow}, 32'd0);
      check("s4_beats", got.size(), 32'd9);
      if (got.size() > 8) for (int j = 0; j < COLS; j++) check("s4_last", got[8][j], 32'd77 + 32'(j));
      if (got.size() > 0) check("s4_first", got[0][3], 32'd1003);

      // ReLU behaviour on column 2
      got.delete();
      go(2);
      bus.en_down = '1;
      for (int j = 0; j < COLS; j++) bus.data_down[j] = 32'(5 + j);
      bus.data_down[2] = 32'hFFFF_FFF6;
      cycle();
      bus.data_down[2] = 32'h0000_0007;
      cycle();
      idle(5);
      check("s5_beats", got.size(), 32'd2);
`ifdef SYS_COLLECT_RELU_EN
      if (got.size() > 0) check("s5_neg", got[0][2], 32'd0);
`else
      if (got.size() > 0) check("s5_neg", got[0][2], 32'hFFFF_FFF6);
`endif
      if (got.size() > 1) check("s5_pos", got[1][2], 32'd7);
      if (got.size() > 0) check("s5_col0", got[0][0], 32'd5);

      // Asynchronous reset mid-tile
      bus.out_ready = 1'b0;
      go(5);
      for (int r = 0; r < 3; r++) begin
         bus.en_down = '1;
         for (int j = 0; j < COLS; j++) bus.data_down[j] = 32'(300 + r);
         cycle();
      end
      bus.en_down = '0;
      check("s6_pre_valid", {31'd0, bus.out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("s6_async_valid", {31'd0, bus.out_valid}, 32'd0);
      check("s6_async_busy", {31'd0, busy}, 32'd0);
      check("s6_async_data", bus.out_data[0], 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      got.delete(); done_seen = 0;
      bus.out_ready = 1'b1;
      go(1);
      skew_row(32'd100);
      idle(4);
      check("s6_beats", got.size(), 32'd1);
      if (got.size() > 0) for (int j = 0; j < COLS; j++) check("s6_data", got[0][j], 32'd100 + 32'(j));
      check("s6_done_pulses", done_seen, 32'd1);

      // Randomized tiles
      for (int t = 0; t < 6; t++) begin
         clr = 1'b1;
         cycle();
         clr = 1'b0;
         go($urandom_range(1, 6));
         for (int c = 0; c < 40; c++) begin
            for (int j = 0; j < COLS; j++) begin
               bus.en_down[j] = ($urandom_range(0, 9) < 6);
               bus.data_down[j] = $urandom;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 15) == 0);
            cfg_num = CNT_W'($urandom_range(0, 5));
            cycle();
         end
         start = 1'b0;
         idle(3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
